// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier FSM states and operand mode encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_UNSIGNED = 1'b0,
        MODE_SIGNED   = 1'b1
    } mode_t;

endpackage

// File: rtl/seq_multiplier_rca.sv
// Ripple-carry adder, N bits, no carry in/out.
module seq_multiplier_rca #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    logic cy;

    always_comb begin
        cy  = 1'b0;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 sequential shift-add multiplier, signed or unsigned operands.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    import alu_pkg::*;

    localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

    state_t             state;
    state_t             state_nx;
    mode_t              mode;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   cnt;
    logic               neg;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] mag;

    assign mode = mode_t'(signed_mode);

    // {acc, mplier} holds the running partial product; low bits shift out
    // of the multiplier as product bits shift in.
    always_comb begin
        addend = mplier[0] ? mcand : '0;
        mag    = {sum, mplier[WIDTH-1:1]};
    end

    seq_multiplier_rca #(
        .N(WIDTH + 1)
    ) u_rca (
        .a  ({1'b0, acc}),
        .b  ({1'b0, addend}),
        .sum(sum)
    );

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            prod_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt <= '0;
                        acc <= '0;
                        if (mode == MODE_SIGNED) begin
                            mcand  <= a[WIDTH-1] ? (~a + 1'b1) : a;
                            mplier <= b[WIDTH-1] ? (~b + 1'b1) : b;
                            neg    <= a[WIDTH-1] ^ b[WIDTH-1];
                        end else begin
                            mcand  <= a;
                            mplier <= b;
                            neg    <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    cnt           <= cnt + 1'b1;
                    {acc, mplier} <= mag;
                    // Sign fix-up lands in the register, keeping it off the output path.
                    if (cnt == LAST)
                        prod_q <= neg ? (~mag + 1'b1) : mag;
                end
                default: ;
            endcase
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed checks for seq_multiplier at WIDTH=8 and WIDTH=4.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    logic        iv8, ir8, sm8, ov8, or8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        iv4, ir4, sm4, ov4, or4, busy4;
    logic [3:0]  a4, b4;
    logic [7:0]  p4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_multiplier #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .signed_mode(sm8),
        .out_valid(ov8), .out_ready(or8),
        .product(p8), .busy(busy8)
    );

    seq_multiplier #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .signed_mode(sm4),
        .out_valid(ov4), .out_ready(or4),
        .product(p4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref4(input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic s);
        int sx, sy, p;
        logic [31:0] pv;
        sx = s ? {{28{x[3]}}, x} : {28'b0, x};
        sy = s ? {{28{y[3]}}, y} : {28'b0, y};
        p  = sx * sy;
        pv = p;
        return pv[7:0];
    endfunction

    task automatic run8(input string tag, input logic [7:0] aa,
                        input logic [7:0] bb, input logic sm,
                        input logic [15:0] exp);
        int lat;
        lat = 0;
        check({tag, "_inready"}, ir8, 1'b1);
        a8 = aa; b8 = bb; sm8 = sm; iv8 = 1'b1; or8 = 1'b0;
        tick();
        iv8 = 1'b0; a8 = ~aa; b8 = ~bb; sm8 = ~sm;
        check({tag, "_busy"}, busy8, 1'b1);
        while (!ov8 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 8);
        check({tag, "_product"}, p8, exp);
        check({tag, "_inready_done"}, ir8, 1'b0);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check({tag, "_ov_after"}, ov8, 1'b0);
        check({tag, "_ir_after"}, ir8, 1'b1);
    endtask

    initial begin
        int lat, seen, acc_cyc, last_cyc;
        logic [3:0] va [5] = '{4'hF, 4'h8, 4'hF, 4'h7, 4'h0};
        logic [3:0] vb [5] = '{4'hF, 4'h8, 4'h1, 4'h8, 4'h9};
        logic       vs [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] xa, xb;
        logic       xs;

        rst_n = 1'b0;
        iv8 = 0; a8 = 0; b8 = 0; sm8 = 0; or8 = 0;
        iv4 = 0; a4 = 0; b4 = 0; sm4 = 0; or4 = 1;
        tick();
        tick();
        check("rst_inready", ir8, 1'b1);
        check("rst_outvalid", ov8, 1'b0);
        check("rst_busy", busy8, 1'b0);
        check("rst_product", p8, 16'h0);
        rst_n = 1'b1;
        tick();

        run8("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        run8("s128x128", 8'h80, 8'h80, 1'b1, 16'h4000);
        run8("sm1x1", 8'hFF, 8'h01, 1'b1, 16'hFFFF);
        run8("s5xm3", 8'h05, 8'hFD, 1'b1, 16'hFFF1);
        run8("u0x200", 8'h00, 8'hC8, 1'b0, 16'h0000);

        // backpressure: 7*9 = 63
        a8 = 8'd7; b8 = 8'd9; sm8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            tick();
            lat++;
        end
        check("bp_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            iv8 = i[0];
            a8 = 8'd1; b8 = 8'd1;
            tick();
            check("bp_outvalid", ov8, 1'b1);
            check("bp_product", p8, 16'h003F);
            check("bp_busy", busy8, 1'b1);
            check("bp_inready", ir8, 1'b0);
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        check("bp_release_ov", ov8, 1'b0);
        check("bp_release_ir", ir8, 1'b1);

        // reset during third RUN cycle
        a8 = 8'd200; b8 = 8'd200; sm8 = 1'b0; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_inready", ir8, 1'b1);
        check("abort_busy", busy8, 1'b0);
        check("abort_product", p8, 16'h0);
        rst_n = 1'b1;
        or8 = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ov8) seen++;
        end
        or8 = 1'b0;
        check("abort_no_ov", seen, 0);
        run8("u3x5", 8'd3, 8'd5, 1'b0, 16'h000F);

        // WIDTH=4 back-to-back, out_ready tied high
        or4 = 1'b1;
        last_cyc = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 5) begin
                xa = va[k]; xb = vb[k]; xs = vs[k];
            end else begin
                xa = 4'($urandom_range(0, 15));
                xb = 4'($urandom_range(0, 15));
                xs = 1'($urandom_range(0, 1));
            end
            a4 = xa; b4 = xb; sm4 = xs; iv4 = 1'b1;
            check("b2b_inready", ir4, 1'b1);
            tick();
            acc_cyc = cyc;
            if (k > 0) check("b2b_interval", acc_cyc - last_cyc, 6);
            last_cyc = acc_cyc;
            a4 = 4'($urandom_range(0, 15));
            b4 = 4'($urandom_range(0, 15));
            lat = 0;
            while (!ov4 && lat < 20) begin
                tick();
                lat++;
            end
            check("b2b_latency", lat, 4);
            check("b2b_product", p4, ref4(xa, xb, xs));
            tick();
        end
        iv4 = 1'b0;
        tick();
        check("b2b_idle", busy4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
